fast_nms: RTL and testbench
===========================

Name: fast_nms

Overview:
- Consumes the raster-ordered FAST corner score stream produced by the score stage, one 13-bit score per pixel.
- Applies 3x3 non-maximum suppression and a minimum-score threshold.
- Emits sparse keypoint records (x, y, score) to the downstream descriptor/collection logic.
- Buffers two previous score lines internally; there is no backpressure path.

Parameters:
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)
- SCORE_W, 13, score width, from shared package
- X_W, $clog2(IMG_W), x coordinate width
- Y_W, $clog2(IMG_H), y coordinate width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  score beat valid this cycle
- in_sof  in  1  qualifies first pixel (0,0) of a frame; sampled only with in_valid
- in_score  in  SCORE_W  unsigned score
- threshold  in  SCORE_W  minimum accepted score; quasi-static, change only between frames
- kp_valid  out  1  single-cycle keypoint strobe
- kp_x  out  X_W  keypoint column
- kp_y  out  Y_W  keypoint row
- kp_score  out  SCORE_W  keypoint score
- frame_done  out  1  single-cycle pulse after last pixel of frame

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset: kp_valid=0, kp_x=0, kp_y=0, kp_score=0, frame_done=0, counters=(0,0), window registers=0. Line-buffer RAM is not cleared.
- Reset mid-frame: all in-flight state is discarded. Output resumes only after a new frame starts.
- Counters col/row advance only on in_valid. Gaps of any length are allowed.
- After beat (IMG_W-1, IMG_H-1), counters auto-wrap to (0,0).
- in_valid with in_sof forces this beat to (0,0), overriding the counters; counting continues from there.
- Line buffers: two, each IMG_W deep. Read-before-write at address col.
  - Row y-1 data shifts into buffer B as row y data is written to buffer A.
- 3x3 window: three 3-entry shift registers (rows y-2, y-1, y), shifted only on in_valid.
- Evaluation is triggered by the accepted beat (col, row) with col>=2 and row>=2.
  - Centre is C=(col-1,row-1).
  - Centre column 0 or IMG_W-1, or centre row 0 or IMG_H-1, is never evaluated.
- Keypoint condition, all unsigned compares:
  - C >= threshold and C != 0;
  - C > each raster-preceding neighbour: UL, U, UR, L;
  - C >= each raster-following neighbour: R, DL, D, DR.
  - This asymmetric tie-break yields exactly one keypoint per flat plateau: the earliest in raster order.
- Latency: kp_valid is asserted the cycle after the triggering beat is accepted. kp_x/kp_y/kp_score are valid with it.
- kp_valid is deasserted on any cycle without a qualifying evaluation. kp_* data holds its last value.
- frame_done pulses the cycle after beat (IMG_W-1, IMG_H-1) is accepted.
  - It may coincide with kp_valid for centre (IMG_W-2, IMG_H-2).
- Stale data safety: after in_sof, no evaluation occurs before row 2 of the new frame. Old-frame line-buffer contents therefore never reach a compare.
- Beats past the frame without in_sof start a new frame via wrap. This is legal.

Decomposition:
- fast_pkg:
  - SCORE_W=13
  - typedef score_t (logic [SCORE_W-1:0])
  - typedef kp_t struct {x, y, score}
  - used by the score stage, fast_nms and downstream blocks
- One sub-module fast_line_buf:
  - parameterised depth/width, synchronous read-before-write, single address, write enable = in_valid
  - instantiated twice, or once at 2*SCORE_W width

Test Plan:
Bench configuration: IMG_W=8, IMG_H=6, threshold=1 unless stated.
- Reset: hold rst_n=0 mid-stream -> all outputs 0 immediately. After release, no kp_valid until a fresh frame's row 2.
- Single peak: all zeros except (3,2)=100 -> exactly one kp_valid {x=3,y=2,score=100}, one cycle after beat (4,3) accepted. frame_done one cycle after beat 47.
- Plateaus:
  - (3,2)=(4,2)=50 -> one kp at (3,2).
  - (3,2)=(3,3)=50 -> one kp at (3,2).
  - 2x2 block of 50 at (3..4,2..3) -> one kp at (3,2).
- Borders: 200 at (0,2), (7,3), (4,0), (4,5) only -> zero kp_valid for the frame.
- Threshold: single peak 20 at (2,2).
  - threshold=21 -> none.
  - threshold=20 -> one kp {2,2,20}.
  - all-zero frame with threshold=0 -> none.
- Gaps and resync:
  - Random in_valid gaps on frame from single-peak scenario -> identical kp set and ordering.
  - in_sof at beat 20 of a frame -> counters restart; next frame_done after 48 beats from that in_sof; no kp from the aborted frame's rows.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared FAST pipeline types: score width, score and keypoint record types,
// and the 3x3 suppression rule used by the NMS stage.
package fast_pkg;

    localparam int SCORE_W    = 13;
    localparam int KP_COORD_W = 16;

    typedef logic [SCORE_W-1:0] score_t;

    typedef struct packed {
        logic [KP_COORD_W-1:0] x;
        logic [KP_COORD_W-1:0] y;
        score_t                score;
    } kp_t;

    // Strict against raster-earlier neighbours, non-strict against later ones,
    // so a flat plateau keeps only its earliest pixel.
    function automatic logic nms_keep(
        input score_t c,
        input score_t thr,
        input score_t ul,
        input score_t u,
        input score_t ur,
        input score_t l,
        input score_t r,
        input score_t dl,
        input score_t d,
        input score_t dr
    );
        logic above_thr;
        logic beats_prev;
        logic holds_next;
        above_thr  = (c >= thr) && (c != '0);
        beats_prev = (c > ul) && (c > u) && (c > ur) && (c > l);
        holds_next = (c >= r) && (c >= dl) && (c >= d) && (c >= dr);
        return above_thr && beats_prev && holds_next;
    endfunction

endpackage

// File: rtl/fast_line_buf.sv
// Single-port line buffer: asynchronous read of the stored word, synchronous
// write at the same address, so a write cycle still reads the old contents.
module fast_line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Contents are deliberately not reset; stale lines are never evaluated.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/fast_nms.sv
// 3x3 non-maximum suppression over a raster FAST score stream; emits sparse
// (x, y, score) keypoints one cycle after the beat that completes each window.
module fast_nms
    import fast_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int X_W   = $clog2(IMG_W),
    parameter int Y_W   = $clog2(IMG_H)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic           in_sof,
    input  score_t         in_score,
    input  score_t         threshold,
    output logic           kp_valid,
    output logic [X_W-1:0] kp_x,
    output logic [Y_W-1:0] kp_y,
    output score_t         kp_score,
    output logic           frame_done
);

    // Handshake: in_valid qualifies one beat per cycle and there is no ready;
    // kp_valid and frame_done are one-cycle strobes the consumer must take.

    logic [X_W-1:0] col_q;
    logic [Y_W-1:0] row_q;
    logic [X_W-1:0] cur_col;
    logic [Y_W-1:0] cur_row;
    logic [X_W-1:0] col_nxt;
    logic [Y_W-1:0] row_nxt;
    logic           last_col;
    logic           last_row;
    logic           synced_q;
    logic           synced_eff;
    logic           trigger;
    logic           keep;

    score_t a_rd;
    score_t b_rd;

    // Window history: index 0 is column col-1, index 1 is column col-2;
    // the incoming beat supplies column col. r0 = row y, r1 = y-1, r2 = y-2.
    score_t r0_q [2];
    score_t r1_q [2];
    score_t r2_q [2];

    always_comb begin
        cur_col  = in_sof ? '0 : col_q;
        cur_row  = in_sof ? '0 : row_q;
        last_col = (cur_col == X_W'(IMG_W - 1));
        last_row = (cur_row == Y_W'(IMG_H - 1));
        col_nxt  = last_col ? '0 : cur_col + 1'b1;
        row_nxt  = cur_row;
        if (last_col) begin
            row_nxt = last_row ? '0 : cur_row + 1'b1;
        end
    end

    // After reset nothing is evaluated until a frame start re-aligns the counters.
    assign synced_eff = synced_q || in_sof;
    assign trigger    = in_valid && synced_eff &&
                        (cur_col >= X_W'(2)) && (cur_row >= Y_W'(2));

    fast_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (2 * SCORE_W),
        .AW    (X_W)
    ) u_line_buf (
        .clk     (clk),
        .we      (in_valid),
        .addr    (cur_col),
        .wr_data ({a_rd, in_score}),
        .rd_data ({b_rd, a_rd})
    );

    assign keep = nms_keep(r1_q[0], threshold,
                           r2_q[1], r2_q[0], b_rd,
                           r1_q[1], a_rd,
                           r0_q[1], r0_q[0], in_score);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            synced_q <= 1'b0;
        end else if (in_valid) begin
            col_q    <= col_nxt;
            row_q    <= row_nxt;
            synced_q <= synced_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r0_q[i] <= '0;
                r1_q[i] <= '0;
                r2_q[i] <= '0;
            end
        end else if (in_valid) begin
            r0_q[1] <= r0_q[0];
            r1_q[1] <= r1_q[0];
            r2_q[1] <= r2_q[0];
            r0_q[0] <= in_score;
            r1_q[0] <= a_rd;
            r2_q[0] <= b_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp_valid   <= 1'b0;
            kp_x       <= '0;
            kp_y       <= '0;
            kp_score   <= '0;
            frame_done <= 1'b0;
        end else begin
            kp_valid   <= trigger && keep;
            frame_done <= in_valid && synced_eff && last_col && last_row;
            if (trigger && keep) begin
                kp_x     <= cur_col - 1'b1;
                kp_y     <= cur_row - 1'b1;
                kp_score <= r1_q[0];
            end
        end
    end

endmodule

// File: tb/tb_fast_nms.sv
// Scoreboard bench for fast_nms on an 8x6 image: frames are built in an array,
// a reference NMS computes the expected keypoints, a monitor checks outputs.
module tb_fast_nms;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int EXP_W = 8 + 3 + 3 + 13;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [12:0] in_score;
    logic [12:0] threshold;
    logic        kp_valid;
    logic [2:0]  kp_x;
    logic [2:0]  kp_y;
    logic [12:0] kp_score;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [EXP_W-1:0] exp_q [$];
    int               fd_exp = 0;

    logic [12:0] frm [NPIX];
    logic [12:0] thr;
    int          drv_idx;
    int          last_acc;
    logic        last_acc_v;

    fast_nms #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_score   (in_score),
        .threshold  (threshold),
        .kp_valid   (kp_valid),
        .kp_x       (kp_x),
        .kp_y       (kp_y),
        .kp_score   (kp_score),
        .frame_done (frame_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // frame-relative index of the beat accepted on the latest edge
    always @(posedge clk) begin
        last_acc_v <= in_valid;
        last_acc   <= drv_idx;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (kp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL kp_unexpected: got x=%0d y=%0d score=%0d, required no keypoint",
                         kp_x, kp_y, kp_score);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                if ({kp_x, kp_y, kp_score} !== e[18:0] || !last_acc_v || last_acc != int'(e[26:19])) begin
                    errors++;
                    $display("FAIL kp_record: got x=%0d y=%0d score=%0d after beat %0d (v=%0d), required x=%0d y=%0d score=%0d after beat %0d",
                             kp_x, kp_y, kp_score, last_acc, last_acc_v,
                             e[18:16], e[15:13], e[12:0], e[26:19]);
                end
            end
        end
        if (frame_done) begin
            checks++;
            if (fd_exp == 0 || !last_acc_v || last_acc != NPIX - 1) begin
                errors++;
                $display("FAIL frame_done: pulse after beat %0d (v=%0d) with %0d pending, required after beat %0d with >=1 pending",
                         last_acc, last_acc_v, fd_exp, NPIX - 1);
            end else begin
                fd_exp--;
            end
        end
    end

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_kp_valid"}, int'(kp_valid), 0);
        check_val({tag, "_kp_x"}, int'(kp_x), 0);
        check_val({tag, "_kp_y"}, int'(kp_y), 0);
        check_val({tag, "_kp_score"}, int'(kp_score), 0);
        check_val({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // frame construction
    task automatic clear_frame();
        for (int i = 0; i < NPIX; i++) frm[i] = '0;
    endtask

    task automatic set_px(input int x, input int y, input logic [12:0] v);
        frm[y * IMG_W + x] = v;
    endtask

    task automatic random_frame(input int max_v);
        for (int i = 0; i < NPIX; i++) frm[i] = 13'($urandom_range(max_v, 0));
    endtask

    // reference model: direct 3x3 rule over the whole frame array
    task automatic push_expected(input int n_beats);
        for (int y = 1; y < IMG_H - 1; y++) begin
            for (int x = 1; x < IMG_W - 1; x++) begin
                int          trig;
                logic [12:0] c;
                logic [12:0] n;
                bit          ok;
                trig = (y + 1) * IMG_W + x + 1;
                c    = frm[y * IMG_W + x];
                ok   = (c >= thr) && (c != 0);
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dy != 0 || dx != 0) begin
                            n = frm[(y + dy) * IMG_W + x + dx];
                            if (dy < 0 || (dy == 0 && dx < 0)) ok = ok && (c > n);
                            else                               ok = ok && (c >= n);
                        end
                    end
                end
                if (ok && trig < n_beats)
                    exp_q.push_back({8'(trig), 3'(x), 3'(y), c});
            end
        end
    endtask

    // driver
    task automatic idle_cycle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drive_beat(input logic [12:0] s, input logic sof, input int idx, input int gap_max);
        int g;
        g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_sof   = 1'($urandom_range(1, 0));
            in_score = 13'($urandom);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_score = s;
        drv_idx  = idx;
    endtask

    task automatic run_frame(input int n_beats, input int gap_max);
        threshold = thr;
        push_expected(n_beats);
        if (n_beats == NPIX) fd_exp++;
        for (int i = 0; i < n_beats; i++) drive_beat(frm[i], (i == 0), i, gap_max);
        repeat (3) idle_cycle();
    endtask

    task automatic single_peak();
        clear_frame();
        set_px(3, 2, 13'd100);
    endtask

    // stimulus
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_score  = '0;
        thr       = 13'd1;
        threshold = thr;
        drv_idx   = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) idle_cycle();

        single_peak();
        run_frame(NPIX, 0);

        clear_frame(); set_px(3, 2, 13'd50); set_px(4, 2, 13'd50);
        run_frame(NPIX, 0);
        clear_frame(); set_px(3, 2, 13'd50); set_px(3, 3, 13'd50);
        run_frame(NPIX, 0);
        clear_frame();
        set_px(3, 2, 13'd50); set_px(4, 2, 13'd50);
        set_px(3, 3, 13'd50); set_px(4, 3, 13'd50);
        run_frame(NPIX, 0);

        clear_frame();
        set_px(0, 2, 13'd200); set_px(7, 3, 13'd200);
        set_px(4, 0, 13'd200); set_px(4, 5, 13'd200);
        run_frame(NPIX, 0);

        clear_frame(); set_px(2, 2, 13'd20);
        thr = 13'd21; run_frame(NPIX, 0);
        thr = 13'd20; run_frame(NPIX, 0);
        clear_frame();
        thr = 13'd0;  run_frame(NPIX, 0);

        thr = 13'd1;
        single_peak();
        run_frame(NPIX, 3);
        for (int k = 0; k < 4; k++) begin
            random_frame(3);
            thr = 13'($urandom_range(2, 0));
            run_frame(NPIX, 2);
        end
        thr = 13'd1;
        random_frame(8191);
        run_frame(NPIX, 1);

        // aborted frame: flat rows 0-1 then in_sof at beat 20
        clear_frame();
        for (int i = 0; i < 2 * IMG_W; i++) frm[i] = 13'd300;
        run_frame(20, 0);
        random_frame(5);
        run_frame(NPIX, 0);

        // reset mid-stream with a held keypoint on the outputs
        single_peak();
        run_frame(30, 0);
        drive_beat(frm[30], 1'b0, 30, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        for (int i = 31; i < 34; i++) drive_beat(frm[i], 1'b0, i, 0);
        idle_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) drive_beat(frm[(i + 34) % NPIX], 1'b0, i + 34, 0);
        repeat (3) idle_cycle();
        single_peak();
        run_frame(NPIX, 0);

        repeat (5) idle_cycle();
        check_val("exp_queue_drained", exp_q.size(), 0);
        check_val("frame_done_count", fd_exp, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
